// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Boot/test program loader for the single-cycle core. It takes field-level
//   requests for lw, sw, R-type and beq, encodes each one as an RV32I word and
//   writes it into instruction memory through a registered one-cycle write
//   stage. A write pointer increments automatically, and a session FSM
//   (IDLE, LOAD, FLUSH, DONE) controls the whole sequence.
//
// Parameters
//   ADDR_W     word-address width of the instruction memory (2**ADDR_W words)
//   BASE_ADDR  word address of the first write; addresses wrap mod 2**ADDR_W
//
// Optional feature
//   ENC_CHECKSUM_EN  when defined, checksum is the running XOR of the words
//                    written this session. When undefined, checksum is 0.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   start         starts a session; sampled only in IDLE or DONE
//   in_valid/in_ready   request handshake; in_ready is combinational
//   in_class      00 R-type, 01 lw, 10 sw, 11 beq
//   in_funct      R-type op: 000 add, 001 sub, 010 slt, 011 and, 100 or
//   in_rd/in_rs1/in_rs2 register fields
//   in_imm        lw/sw imm[11:0]; beq byte offset[12:1]
//   in_last       final request of the session
//   mem_we/mem_addr/mem_wdata   registered instruction-memory write port
//   busy, done    FSM in LOAD/FLUSH, FSM in DONE
//   err           sticky: illegal funct or overflow in this session
//   count         words written this session
//   checksum      see ENC_CHECKSUM_EN
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [2:0]        in_funct,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count,
    output logic [31:0]       checksum
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    localparam logic [1:0] CLS_R  = 2'b00;
    localparam logic [1:0] CLS_LW = 2'b01;
    localparam logic [1:0] CLS_SW = 2'b10;
    localparam logic [1:0] CLS_BQ = 2'b11;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BQ = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [PTR_W-1:0]   ptr;
    logic               session_clr;
    logic               err_set;
    logic               accept;
    logic               legal;
    logic               write_c;
    logic [6:0]         f7;
    logic [2:0]         f3;
    logic [31:0]        word;

    // The extra MSB of ptr marks a full memory and blocks further requests.
    assign in_ready = (state == S_LOAD) & ~ptr[ADDR_W];
    assign accept   = in_valid & in_ready;
    assign legal    = (in_class != CLS_R) | (in_funct <= 3'd4);
    assign write_c  = accept & legal;
    assign count    = ptr;

    // R-type funct7/funct3 for the supported ALU operations
    always_comb begin
        f7 = 7'b0000000;
        f3 = 3'b000;
        case (in_funct)
            3'b000:  f3 = 3'b000;
            3'b001:  begin f3 = 3'b000; f7 = 7'b0100000; end
            3'b010:  f3 = 3'b010;
            3'b011:  f3 = 3'b111;
            3'b100:  f3 = 3'b110;
            default: f3 = 3'b000;
        endcase
    end

    // Instruction word assembly
    always_comb begin
        word = 32'h0;
        case (in_class)
            CLS_R:   word = {f7, in_rs2, in_rs1, f3, in_rd, OP_R};
            CLS_LW:  word = {in_imm, in_rs1, 3'b010, in_rd, OP_LW};
            CLS_SW:  word = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                             in_imm[4:0], OP_SW};
            // in_imm holds offset[12:1], so offset bit k lives in in_imm[k-1].
            CLS_BQ:  word = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, 3'b000,
                             in_imm[3:0], in_imm[10], OP_BQ};
            default: word = 32'h0;
        endcase
    end

    // Session FSM: next state, session clear and error set
    always_comb begin
        next_state  = state;
        session_clr = 1'b0;
        err_set     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state  = S_LOAD;
                    session_clr = 1'b1;
                end
            end
            S_LOAD: begin
                if (accept & ~legal) begin
                    err_set = 1'b1;
                end
                if (accept & in_last) begin
                    next_state = S_FLUSH;
                end else if (ptr[ADDR_W]) begin
                    // The memory filled before the last request arrived.
                    next_state = S_FLUSH;
                    err_set    = 1'b1;
                end
            end
            S_FLUSH: next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == S_LOAD) | (next_state == S_FLUSH);
            done  <= (next_state == S_DONE);
        end
    end

    // Write pointer and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            err <= 1'b0;
        end else if (session_clr) begin
            ptr <= '0;
            err <= 1'b0;
        end else begin
            if (write_c) begin
                ptr <= ptr + PTR_W'(1);
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // One-cycle write stage toward instruction memory
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            mem_we <= write_c;
            if (write_c) begin
                mem_addr  <= ADDR_W'(BASE_ADDR) + ptr[ADDR_W-1:0];
                mem_wdata <= word;
            end
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] chk_acc;

    // Running XOR, advanced together with the write stage so that it already
    // includes the word during its mem_we cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_acc <= 32'h0;
        end else if (session_clr) begin
            chk_acc <= 32'h0;
        end else if (write_c) begin
            chk_acc <= chk_acc ^ word;
        end
    end

    assign checksum = chk_acc;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder. A scoreboard queue receives the expected
//   write (address, word, count, checksum) when a legal request is accepted.
//   A negedge monitor pops the queue and compares it on every mem_we.
//   The memory is small (ADDR_W=4) and BASE_ADDR is 14, so both the overflow
//   path and address wrap are exercised.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned BASE_ADDR = 14;
    localparam int unsigned CAP       = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_class;
    logic [2:0]        in_funct;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [11:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;
    logic [31:0]       checksum;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct(in_funct),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [ADDR_W:0]   cnt;
        logic [31:0]       chk;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          model_ptr;
    logic [31:0] model_chk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_chk(input logic [31:0] acc);
`ifdef ENC_CHECKSUM_EN
        return acc;
`else
        return 32'h0 & acc;
`endif
    endfunction

    // Reference encoder written from the RV32I base formats (R/I/S/B)
    function automatic logic [31:0] ref_enc(input logic [1:0] cls, input logic [2:0] f,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [11:0] imm);
        logic [31:0] w;
        logic [12:0] off;
        logic [2:0]  fn3;
        off = {imm, 1'b0};
        w   = 32'h0;
        case (cls)
            2'b00: begin
                fn3 = (f == 3'd2) ? 3'b010 : (f == 3'd3) ? 3'b111 :
                      (f == 3'd4) ? 3'b110 : 3'b000;
                w = 32'h33 | (32'(rd) << 7) | (32'(fn3) << 12) | (32'(rs1) << 15)
                    | (32'(rs2) << 20) | ((f == 3'd1) ? 32'h4000_0000 : 32'h0);
            end
            2'b01: w = 32'h03 | (32'(rd) << 7) | (32'd2 << 12) | (32'(rs1) << 15)
                       | (32'(imm) << 20);
            2'b10: w = 32'h23 | (32'(imm[4:0]) << 7) | (32'd2 << 12) | (32'(rs1) << 15)
                       | (32'(rs2) << 20) | (32'(imm[11:5]) << 25);
            default: w = 32'h63 | (32'(off[11]) << 7) | (32'(off[4:1]) << 8)
                         | (32'(rs1) << 15) | (32'(rs2) << 20)
                         | (32'(off[10:5]) << 25) | (32'(off[12]) << 31);
        endcase
        return w;
    endfunction

    // Scoreboard monitor: every write must match the oldest expected entry
    always @(negedge clk) begin
        if (rst && mem_we) begin
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                check("mem_wdata", 64'(mem_wdata), 64'(e.data));
                check("count_at_write", 64'(count), 64'(e.cnt));
                check("checksum_at_write", 64'(checksum), 64'(e.chk));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_ptr = 0;
        model_chk = 32'h0;
    endtask

    // Drives one request, waits (bounded) for acceptance, and queues the expected write.
    task automatic send(input logic [1:0] cls, input logic [2:0] f, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                        input logic last, input logic legal, input logic [31:0] word);
        logic acc;
        exp_t e;
        in_class = cls; in_funct = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_last = last; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("accepted", 64'(acc), 64'd1);
        if (acc && legal) begin
            model_chk = model_chk ^ word;
            e.addr = ADDR_W'(BASE_ADDR + model_ptr);
            e.data = word;
            model_ptr++;
            e.cnt  = (ADDR_W + 1)'(model_ptr);
            e.chk  = exp_chk(model_chk);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
        end
        check("done", 64'(done), 64'd1);
    endtask

    initial begin
        logic [1:0]  c;
        logic [2:0]  f;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_class = 2'b00; in_funct = 3'b000;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 12'h0; in_last = 1'b0;
        model_ptr = 0; model_chk = 32'h0;

        #12;
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 64'(in_ready), 64'd0);

        // Session 1: add, lw, sw, illegal funct, beq with last
        pulse_start();
        check("load_busy", 64'(busy), 64'd1);
        check("load_in_ready", 64'(in_ready), 64'd1);
        send(2'b00, 3'b000, 5'd3, 5'd1, 5'd2, 12'h000, 1'b0, 1'b1, 32'h002081B3);
        send(2'b01, 3'b000, 5'd5, 5'd2, 5'd0, 12'd8,   1'b0, 1'b1, 32'h00812283);
        send(2'b10, 3'b000, 5'd0, 5'd2, 5'd5, 12'd12,  1'b0, 1'b1, 32'h00512623);
        send(2'b00, 3'b111, 5'd7, 5'd1, 5'd1, 12'h000, 1'b0, 1'b0, 32'h0);
        check("illegal_err", 64'(err), 64'd1);
        check("illegal_count", 64'(count), 64'd3);
        send(2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 12'hFFE, 1'b1, 1'b1, 32'hFE208EE3);
        wait_done();
        check("done_busy", 64'(busy), 64'd0);
        check("done_count", 64'(count), 64'd4);
        check("done_checksum", 64'(checksum), 64'(exp_chk(model_chk)));
        check("done_in_ready", 64'(in_ready), 64'd0);

        // Session 2: fill all 16 words without in_last; addresses wrap past 15
        pulse_start();
        check("restart_err", 64'(err), 64'd0);
        check("restart_count", 64'(count), 64'd0);
        check("restart_done", 64'(done), 64'd0);
        for (int i = 0; i < int'(CAP); i++) begin
            c = 2'($urandom_range(0, 3));
            f = 3'($urandom_range(0, 4));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            imm = 12'($urandom);
            send(c, f, rd, rs1, rs2, imm, 1'b0, 1'b1, ref_enc(c, f, rd, rs1, rs2, imm));
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        // A pending request must not get through while the memory is full
        in_class = 2'b00; in_funct = 3'b000; in_valid = 1'b1;
        wait_done();
        in_valid = 1'b0;
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_count", 64'(count), 64'(CAP));
        check("sb_drained_ovf", 64'(sb.size()), 64'd0);

        // Session 3: an illegal request with in_last still ends the session
        pulse_start();
        send(2'b00, 3'b101, 5'd1, 5'd1, 5'd1, 12'h000, 1'b1, 1'b0, 32'h0);
        wait_done();
        check("ill_last_err", 64'(err), 64'd1);
        check("ill_last_count", 64'(count), 64'd0);

        // Session 4: reset asserted while a write is pending
        pulse_start();
        send(2'b00, 3'b001, 5'd4, 5'd5, 5'd6, 12'h000, 1'b0, 1'b1, ref_enc(2'b00, 3'b001, 5'd4, 5'd5, 5'd6, 12'h0));
        send(2'b00, 3'b100, 5'd7, 5'd8, 5'd9, 12'h000, 1'b0, 1'b1, ref_enc(2'b00, 3'b100, 5'd7, 5'd8, 5'd9, 12'h0));
        check("pending_we", 64'(mem_we), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_we", 64'(mem_we), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        send(2'b01, 3'b000, 5'd10, 5'd11, 5'd0, 12'h7FF, 1'b0, 1'b1, ref_enc(2'b01, 3'b0, 5'd10, 5'd11, 5'd0, 12'h7FF));
        send(2'b11, 3'b000, 5'd0, 5'd3, 5'd4, 12'h004, 1'b1, 1'b1, ref_enc(2'b11, 3'b0, 5'd0, 5'd3, 5'd4, 12'h004));
        wait_done();
        check("resume_count", 64'(count), 64'd2);
        check("resume_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained_end", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
